// File: rtl/dsp48_pfb_out_stage_pkg.sv
// Shared definitions for the PFB DSP48 MAC-cascade output stage.
//   - DSP48 datapath widths (P, A, B ports)
//   - pipeline-latency helper for a tap chain of a given length
//   - rounding-mode selector
//   - sideband struct carried alongside each sample
//   - 16-bit saturation helper
package dsp48_pfb_out_stage_pkg;

    localparam int P_W   = 48;
    localparam int A_W   = 25;
    localparam int B_W   = 16;
    localparam int OUT_W = 16;

    // AREG2 + MREG1 + PREG1 for the first tap, plus one P stage per cascaded tap.
    localparam int unsigned BASE_PIPE_LAT = 4;

    function automatic int unsigned pipe_lat_for_taps(input int unsigned taps);
        return BASE_PIPE_LAT + taps - 1;
    endfunction

    typedef enum logic {
        RND_CONVERGENT = 1'b0,
        RND_TRUNCATE   = 1'b1
    } rnd_mode_t;

    localparam rnd_mode_t RND_MODE = RND_CONVERGENT;

    // Widest phase index carried by the sideband; stage PHASE_W must not exceed it.
    localparam int SB_PHASE_W = 11;

    typedef struct packed {
        logic [SB_PHASE_W-1:0] phase;
        logic                  last;
    } sband_t;

    localparam logic signed [P_W:0] SAT_MAX = 32767;
    localparam logic signed [P_W:0] SAT_MIN = -32768;

    function automatic logic [OUT_W-1:0] sat16(input logic signed [P_W:0] v);
        if (v > SAT_MAX)      return 16'h7FFF;
        else if (v < SAT_MIN) return 16'h8000;
        else                  return v[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/pfb_out_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy tracking.
//   clk, sync_reset        : clock, synchronous active-high reset
//   wr_en, wr_data         : push side (no backpressure; drops when full)
//   rd_en                  : pop when rd_valid is high
//   rd_data, rd_valid      : head word and its valid
//   almost_full            : registered, occupancy >= AF_THRESH
//   overflow               : sticky, a push was dropped while full
// A word becomes visible on rd_valid one clk after it is written; there is
// no write-to-read bypass. A push into a full FIFO succeeds if a pop happens
// on the same edge.
module pfb_out_fifo
    import dsp48_pfb_out_stage_pkg::*;
#(
    parameter int W         = 28,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 10
) (
    input  logic         clk,
    input  logic         sync_reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    output logic         almost_full,
    output logic         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_vis, count_nxt;
    logic          vis, full, pop, push;

    assign full = (count == CW'(DEPTH));
    assign pop  = vis & rd_en;
    assign push = wr_en & (~full | pop);

    // count_vis excludes this edge's push: a freshly written word only shows
    // on rd_valid one clk later.
    always_comb begin
        count_vis = count - CW'(pop);
        count_nxt = count_vis + CW'(push);
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            vis         <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count       <= count_nxt;
            vis         <= (count_vis != '0);
            almost_full <= (count_nxt >= CW'(AF_THRESH));
            if (wr_en & ~push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data  = mem[rd_ptr];
    assign rd_valid = vis;

endmodule

// File: rtl/dsp48_pfb_out_stage.sv
// Consumer end of the PFB DSP48 MAC cascade.
//   clk, sync_reset     : clock, synchronous active-high reset
//   ce                  : clock enable shared with the MAC chain
//   valid_in/phase_in/last_in : sideband presented with the chain's a/b inputs
//   p_in                : P output of the last MAC in the chain
//   m_axis_*            : AXI-Stream master (tdata = rounded/saturated 16-bit,
//                         tuser = phase, tlast = frame end)
//   almost_full         : output FIFO occupancy >= AF_THRESH
//   overflow            : sticky, a result was dropped with the FIFO full
// Sideband is delayed PIPE_LAT ce-qualified stages so the tail lines up with
// p_in, captured once per sample, rounded half-to-even at SHIFT, saturated to
// 16 bits, and queued in an FWFT FIFO.
module dsp48_pfb_out_stage
    import dsp48_pfb_out_stage_pkg::*;
#(
    parameter int PIPE_LAT   = pipe_lat_for_taps(1),
    parameter int SHIFT      = 15,
    parameter int PHASE_W    = SB_PHASE_W,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = 10
) (
    input  logic               clk,
    input  logic               sync_reset,
    input  logic               ce,
    input  logic               valid_in,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic               last_in,
    input  logic [47:0]        p_in,
    output logic [15:0]        m_axis_tdata,
    output logic [PHASE_W-1:0] m_axis_tuser,
    output logic               m_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               almost_full,
    output logic               overflow
);

    localparam int RW     = P_W + 1;
    localparam int FW     = OUT_W + PHASE_W + 1;
    localparam int STAGES = 1;
    localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);

    // ---------------- alignment delay line ----------------
    logic [PIPE_LAT-1:0] dl_vld;
    sband_t              dl_sb [PIPE_LAT];
    sband_t              sb_in;
    logic                taken, capture;

    always_comb begin
        sb_in       = '0;
        sb_in.phase = SB_PHASE_W'(phase_in);
        sb_in.last  = last_in;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            dl_vld <= '0;
        end else if (ce) begin
            dl_vld[0] <= valid_in;
            for (int i = 1; i < PIPE_LAT; i++) dl_vld[i] <= dl_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            dl_sb[0] <= sb_in;
            for (int i = 1; i < PIPE_LAT; i++) dl_sb[i] <= dl_sb[i-1];
        end
    end

    // The tail can sit for several clks while ce is low; taken makes sure it
    // is captured only once, and clears whenever the tail advances.
    assign capture = dl_vld[PIPE_LAT-1] & ~taken;

    always_ff @(posedge clk) begin
        if (sync_reset)   taken <= 1'b0;
        else if (ce)      taken <= 1'b0;
        else if (capture) taken <= 1'b1;
    end

    // ---------------- stage R: round ----------------
    logic signed [RW-1:0] p_ext, trunc, r_sum, r_q;
    logic [SHIFT-1:0]     frac;
    logic                 up;
    sband_t               r_sb, s_sb;
    logic [STAGES:0]      vld_pipe;
    logic [OUT_W-1:0]     s_data;

    always_comb begin
        p_ext = {p_in[P_W-1], p_in};
        trunc = p_ext >>> SHIFT;
        frac  = p_in[SHIFT-1:0];
        if (RND_MODE == RND_CONVERGENT)
            up = (frac > HALF) || ((frac == HALF) && trunc[0]);
        else
            up = 1'b0;
        r_sum = trunc + RW'(up);
    end

    always_ff @(posedge clk) begin
        if (sync_reset) vld_pipe <= '0;
        else            vld_pipe <= {vld_pipe[STAGES-1:0], capture};
    end

    // Datapath registers run freely; vld_pipe qualifies them.
    always_ff @(posedge clk) begin
        r_q    <= r_sum;
        r_sb   <= dl_sb[PIPE_LAT-1];
        s_data <= sat16(r_q);
        s_sb   <= r_sb;
    end

    // ---------------- output FIFO ----------------
    logic [FW-1:0] wr_word, rd_word;

    assign wr_word = {s_data, PHASE_W'(s_sb.phase), s_sb.last};

    pfb_out_fifo #(
        .W         (FW),
        .DEPTH     (FIFO_DEPTH),
        .AF_THRESH (AF_THRESH)
    ) u_fifo (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .wr_en       (vld_pipe[STAGES]),
        .wr_data     (wr_word),
        .rd_en       (m_axis_tready),
        .rd_data     (rd_word),
        .rd_valid    (m_axis_tvalid),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = rd_word;

endmodule

// File: tb/tb_dsp48_pfb_out_stage.sv
module tb_dsp48_pfb_out_stage;

    logic        clk = 1'b0;
    logic        sync_reset, ce, valid_in, last_in, m_axis_tready;
    logic [10:0] phase_in;
    logic [47:0] p_in, p_src;
    logic [47:0] pp [4];
    logic [15:0] m_axis_tdata;
    logic [10:0] m_axis_tuser;
    logic        m_axis_tlast, m_axis_tvalid, almost_full, overflow;

    dsp48_pfb_out_stage dut (
        .clk           (clk),
        .sync_reset    (sync_reset),
        .ce            (ce),
        .valid_in      (valid_in),
        .phase_in      (phase_in),
        .last_in       (last_in),
        .p_in          (p_in),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .almost_full   (almost_full),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // MAC chain model: p_src presented with valid_in shows on p_in after 4 ce edges.
    always @(posedge clk) begin
        if (ce) begin
            pp[0] <= p_src;
            pp[1] <= pp[0];
            pp[2] <= pp[1];
            pp[3] <= pp[2];
        end
    end
    assign p_in = pp[3];

    typedef struct packed {
        logic [15:0] d;
        logic [10:0] ph;
        logic        l;
    } beat_t;

    beat_t exp_q [$];
    beat_t mon_e;
    int    checks = 0;
    int    failures = 0;
    int    nbeats = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: a beat transfers on the next posedge when tvalid & tready.
    always @(negedge clk) begin
        if (!sync_reset && m_axis_tvalid && m_axis_tready) begin
            nbeats++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_beat: got data=%h user=%0d last=%b expected no beat",
                         m_axis_tdata, m_axis_tuser, m_axis_tlast);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", 64'(m_axis_tdata), 64'(mon_e.d));
                chk("beat_user", 64'(m_axis_tuser), 64'(mon_e.ph));
                chk("beat_last", 64'(m_axis_tlast), 64'(mon_e.l));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [47:0] p, input logic [10:0] ph, input logic l,
                        input logic [15:0] expd, input bit expect_it);
        valid_in = 1'b1;
        p_src    = p;
        phase_in = ph;
        last_in  = l;
        if (expect_it) exp_q.push_back('{expd, ph, l});
        tick(1);
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic wait_drain(input int maxc, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: got %0d beats outstanding expected 0", name, exp_q.size());
        end
        tick(2);
        chk({name, "_idle"}, 64'(m_axis_tvalid), 64'd0);
    endtask

    // Rounding / saturation vectors with hand-computed results (SHIFT=15).
    logic [47:0] rv_p [7] = '{48'h0000_0000_4000, 48'h0000_0000_C000, 48'hFFFF_FFFF_C000,
                              48'h0000_0001_4000, 48'h0000_8000_0000, 48'hFFFF_8000_0000,
                              48'h0000_4000_0000};
    logic [15:0] rv_e [7] = '{16'h0000, 16'h0002, 16'h0000, 16'h0002,
                              16'h7FFF, 16'h8000, 16'h7FFF};

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int sent, nb0;
        sync_reset    = 1'b1;
        ce            = 1'b1;
        valid_in      = 1'b0;
        last_in       = 1'b0;
        phase_in      = '0;
        p_src         = '0;
        m_axis_tready = 1'b1;
        tick(6);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_af",     64'(almost_full),   64'd0);
        chk("rst_ov",     64'(overflow),      64'd0);
        sync_reset = 1'b0;
        tick(2);

        // ---- rounding / saturation, with first-sample latency ----
        send(rv_p[0], 11'd0, 1'b0, rv_e[0], 1'b1);
        tick(6);
        chk("lat_early", 64'(m_axis_tvalid), 64'd0);
        tick(1);
        chk("lat_tvalid", 64'(m_axis_tvalid), 64'd1);
        for (int i = 1; i < 7; i++)
            send(rv_p[i], 11'(i), (i == 6), rv_e[i], 1'b1);
        wait_drain(40, "round_drain");

        // ---- ce gaps: ce pattern 1,0,0,1 ----
        nb0  = nbeats;
        sent = 0;
        for (int c = 0; c < 60; c++) begin
            ce = (c % 4 == 0) || (c % 4 == 3);
            if (ce && sent < 8) begin
                valid_in = 1'b1;
                p_src    = 48'(sent + 1) << 15;
                phase_in = 11'(sent);
                last_in  = (sent == 7);
                exp_q.push_back('{16'(sent + 1), 11'(sent), (sent == 7)});
                sent++;
            end else begin
                valid_in = 1'b0;
                last_in  = 1'b0;
            end
            tick(1);
        end
        ce       = 1'b1;
        valid_in = 1'b0;
        last_in  = 1'b0;
        wait_drain(40, "cegap_drain");
        chk("cegap_beats", 64'(nbeats - nb0), 64'd8);

        // ---- backpressure: 17 samples into a stalled 16-deep FIFO ----
        m_axis_tready = 1'b0;
        for (int c = 0; c < 28; c++) begin
            if (c < 17) begin
                valid_in = 1'b1;
                p_src    = 48'(100 + c) << 15;
                phase_in = 11'(c);
                if (c < 16) exp_q.push_back('{16'(100 + c), 11'(c), 1'b0});
            end else begin
                valid_in = 1'b0;
            end
            tick(1);
            // sample c is written 6 edges after issue; the 10th write is c=15,
            // the dropped 17th write is c=22
            chk("bp_af", 64'(almost_full), 64'(c >= 15));
            chk("bp_ov", 64'(overflow),    64'(c >= 22));
        end
        m_axis_tready = 1'b1;
        wait_drain(40, "bp_drain");
        chk("bp_ov_sticky", 64'(overflow),    64'd1);
        chk("bp_af_clear",  64'(almost_full), 64'd0);

        // ---- reset mid-stream: 5 queued, 3 in flight ----
        m_axis_tready = 1'b0;
        for (int c = 0; c < 11; c++) begin
            valid_in = (c < 8);
            p_src    = 48'(300 + c) << 15;
            phase_in = 11'(c);
            tick(1);
        end
        valid_in   = 1'b0;
        sync_reset = 1'b1;
        tick(1);
        sync_reset = 1'b0;
        chk("mrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mrst_af",     64'(almost_full),   64'd0);
        chk("mrst_ov",     64'(overflow),      64'd0);
        tick(10);
        chk("mrst_flushed", 64'(m_axis_tvalid), 64'd0);
        m_axis_tready = 1'b1;
        send(48'h0000_0002_8000, 11'd42, 1'b1, 16'h0005, 1'b1);
        tick(6);
        chk("mrst_lat_early", 64'(m_axis_tvalid), 64'd0);
        tick(1);
        chk("mrst_lat_tvalid", 64'(m_axis_tvalid), 64'd1);
        wait_drain(20, "mrst_drain");

        // ---- full FIFO with push and pop on the same edge ----
        m_axis_tready = 1'b0;
        for (int c = 0; c < 23; c++) begin
            if (c < 17) begin
                valid_in = 1'b1;
                p_src    = 48'(200 + c) << 15;
                phase_in = 11'(c);
                exp_q.push_back('{16'(200 + c), 11'(c), 1'b0});
            end else begin
                valid_in = 1'b0;
            end
            m_axis_tready = (c == 22);
            tick(1);
        end
        m_axis_tready = 1'b0;
        chk("full_pp_ov", 64'(overflow),    64'd0);
        chk("full_pp_af", 64'(almost_full), 64'd1);
        tick(3);
        chk("full_pp_ov_hold", 64'(overflow),    64'd0);
        chk("full_pp_af_hold", 64'(almost_full), 64'd1);
        m_axis_tready = 1'b1;
        wait_drain(40, "full_pp_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp48_pfb_out_stage.md
Name: dsp48_pfb_out_stage

Overview:
- Consumer end of the PFB DSP48 MAC cascade.
- Takes the 48-bit P result from the last MAC in a tap chain and realigns it with a sideband valid/phase/last that is delayed to match the DSP pipeline.
- Applies convergent rounding and saturation to 16 bits.
- Buffers results in a small first-word-fall-through (FWFT) FIFO driving an AXI-Stream master.
- Asserts almost_full so the controller can drop the chain's ce.

Parameters:
- PIPE_LAT, 4, number of ce-qualified stages from the MAC chain input to a valid P (AREG2 + MREG1 + PREG1, plus one per cascaded tap).
- SHIFT, 15, P bit position of the output LSB (binary point).
- PHASE_W, 11, width of the phase/tuser sideband.
- FIFO_DEPTH, 16, output FIFO entries (power of 2).
- AF_THRESH, 10, occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  clock
- sync_reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable shared with the MAC chain
- valid_in  in  1  sample valid, presented with the chain's a/b inputs
- phase_in  in  PHASE_W  polyphase index, presented with valid_in
- last_in  in  1  end of frame, presented with valid_in
- p_in  in  48  P output of the last MAC in the chain
- m_axis_tdata  out  16  rounded, saturated result
- m_axis_tuser  out  PHASE_W  phase index
- m_axis_tlast  out  1  frame end
- m_axis_tvalid  out  1  AXI-S valid
- m_axis_tready  in  1  AXI-S ready
- almost_full  out  1  FIFO occupancy >= AF_THRESH
- overflow  out  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset values:
  - All delay-line valid bits, the taken flag, the pipeline valids and the FIFO pointers are 0.
  - m_axis_tvalid=0, almost_full=0, overflow=0.
  - tdata, tuser and tlast are don't-care while tvalid=0.
- Alignment delay line:
  - PIPE_LAT stages of {valid, phase, last}, shifting only on clock edges where ce=1.
  - The tail entry corresponds to the value currently held in p_in.
- Capture:
  - p_in and the tail sideband are captured into stage R on the first edge where tail.valid=1 and taken=0; taken is then set.
  - taken clears on any edge where ce=1, since the tail then advances.
  - Guarantees exactly one capture per sample regardless of ce gaps.
- Stage R (1 clk, free-running, not ce-gated):
  - trunc = p_in >>> SHIFT (arithmetic); frac = p_in[SHIFT-1:0]; half = 2^(SHIFT-1).
  - up = (frac > half) or (frac == half and trunc[0] == 1), i.e. round half to even.
  - r = trunc + up, computed in 49 bits to avoid wrap.
- Stage S (1 clk):
  - If r > 32767, output 0x7FFF; if r < -32768, output 0x8000; otherwise r[15:0].
  - Sideband follows the data unchanged.
- FIFO write:
  - Stage S valid writes {data, phase, last} on the next edge.
  - FWFT: m_axis_tvalid rises one clk after the write when the FIFO was empty.
  - Minimum latency is aligned capture edge + 3 clks to tvalid.
- AXI-S:
  - Pop on tvalid & tready.
  - Output holds stable while tvalid=1 and tready=0.
- Simultaneous push and pop when full: the pop frees the slot, the push succeeds, and overflow stays unchanged.
- Push when full with no pop: data is dropped and overflow is set until sync_reset.
- Push and pop when empty: no bypass; the word appears the next clk.
- almost_full is registered from the post-update occupancy and deasserts once occupancy < AF_THRESH.
- Reset mid-operation: every in-flight sample in the delay line, pipeline and FIFO is discarded, and outputs return to reset values on the edge after sync_reset is sampled high.

Decomposition:
- Shared package holds:
  - DSP constants: P_W=48, A_W=25, B_W=16.
  - Default PIPE_LAT per tap count.
  - The rounding-mode constant.
  - A sideband struct typedef {phase, last}.
- One natural sub-module: pfb_out_fifo, a synchronous FWFT FIFO with occupancy count, almost_full and overflow. It is reused by other channelizer stages.

Test Plan:
- Rounding, all with SHIFT=15 and ce=1:
  - p_in=0x4000 → tdata 0x0000.
  - p_in=0xC000 → 0x0002.
  - p_in=-16384 → 0x0000.
  - p_in=0x14000 → 0x0002.
- Saturation:
  - p_in=2^31 → 0x7FFF.
  - p_in=-2^31 → 0x8000.
  - p_in=2^30 → 0x7FFF.
- ce gaps:
  - Stimulus: valid_in pulses with phase 0..7; ce toggles 1,0,0,1 in a pattern; p_in is modelled as a ce-gated 4-deep delay.
  - Required: exactly 8 beats out, phases 0..7 in order, tlast on phase 7, no duplicates.
- Backpressure:
  - Stimulus: tready=0 while continuous valid with ce=1.
  - Required: almost_full=1 after the 10th write; overflow=0 through 16 entries; the 17th sample is dropped and sets overflow.
  - Then tready=1: 16 beats in order.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, tready=1 on the same clk as a write.
  - Required: occupancy stays 16, overflow=0, data order preserved.
- Reset mid-stream:
  - Stimulus: sync_reset asserted for 1 clk with 5 entries queued and 3 in flight.
  - Required: the next clk has tvalid=0, almost_full=0 and overflow=0; subsequent samples emerge with latency 3 clks after aligned capture.
